// File: rtl/cgra_exec_controller_pkg.sv
// Shared types and array geometry for the CGRA execution controller.
//   ctrl_state_t  : controller FSM states
//   cfg_entry_t   : one per-PE context entry (stream input and output register share it)
//   entry_in_range: true when the entry addresses a PE that exists in the array
// Geometry constants mirror the values the ElasticCGRA build uses.
package cgra_exec_controller_pkg;

  localparam int PE_ROW_SIZE             = 3;
  localparam int PE_COLUMN_SIZE          = 3;
  localparam int PE_ROW_BIT_LENGTH       = 2;
  localparam int PE_COLUMN_BIT_LENGTH    = 2;
  localparam int CONTEXT_SIZE_BIT_LENGTH = 3;
  localparam int INPUT_NUM_BIT_LENGTH    = 3;
  localparam int NEIGHBOR_PE_NUM         = 4;
  localparam int OPERATION_BIT_LENGTH    = 4;
  localparam int DATA_WIDTH              = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ARM  = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } ctrl_state_t;

  typedef struct packed {
    logic [PE_ROW_BIT_LENGTH-1:0]       row;
    logic [PE_COLUMN_BIT_LENGTH-1:0]    col;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] index;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    in1;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    in2;
    logic [NEIGHBOR_PE_NUM-1:0]         out;
    logic [OPERATION_BIT_LENGTH-1:0]    op;
    logic [DATA_WIDTH-1:0]              const_data;
  } cfg_entry_t;

  function automatic logic entry_in_range(input cfg_entry_t e);
    return (32'(e.row) < 32'(PE_ROW_SIZE)) && (32'(e.col) < 32'(PE_COLUMN_SIZE));
  endfunction

endpackage

// File: rtl/cgra_exec_controller_if.sv
// Context-entry stream between the host and the execution controller.
//   master: host side, drives cfg_valid/cfg_last and the entry fields, observes cfg_ready
//   slave : controller side
interface cgra_exec_controller_if;
  import cgra_exec_controller_pkg::*;

  logic                               cfg_valid;
  logic                               cfg_ready;
  logic                               cfg_last;
  logic [PE_ROW_BIT_LENGTH-1:0]       cfg_row;
  logic [PE_COLUMN_BIT_LENGTH-1:0]    cfg_col;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] cfg_index;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_in1;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_in2;
  logic [NEIGHBOR_PE_NUM-1:0]         cfg_out;
  logic [OPERATION_BIT_LENGTH-1:0]    cfg_op;
  logic [DATA_WIDTH-1:0]              cfg_const;

  modport master (
    output cfg_valid, cfg_last, cfg_row, cfg_col, cfg_index,
           cfg_in1, cfg_in2, cfg_out, cfg_op, cfg_const,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_last, cfg_row, cfg_col, cfg_index,
           cfg_in1, cfg_in2, cfg_out, cfg_op, cfg_const,
    output cfg_ready
  );

endinterface

// File: rtl/cgra_ctrl_run_counter.sv
// Execution-length counter.
//   load    : latch limit and clear the count
//   enable  : count one execution cycle
//   limit   : requested number of execution cycles (0 = run forever)
//   terminal: high during the last enabled cycle (count == limit-1); never for limit 0
module cgra_ctrl_run_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] count_q, count_d;

  // Next limit/count: load wins, otherwise count while enabled.
  always_comb begin
    limit_d = limit_q;
    count_d = count_q;
    if (load) begin
      limit_d = limit;
      count_d = {WIDTH{1'b0}};
    end else if (enable) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      limit_q <= {WIDTH{1'b0}};
      count_q <= {WIDTH{1'b0}};
    end else begin
      limit_q <= limit_d;
      count_q <= count_d;
    end
  end

  // A zero limit means free-run, so it can never reach terminal count.
  assign terminal = enable && (limit_q != {WIDTH{1'b0}}) && (count_q == (limit_q - ONE));

endmodule

// File: rtl/cgra_exec_controller.sv
// Host-side sequencer for the elastic CGRA array.
// Accepts context entries over the cfg stream, replays each in-range entry onto the
// array's config bus as a one-cycle write_config_data strobe (latency 1), then holds
// start_exec for run_cycles cycles and reports done / cfg_error.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   cmd_load, cmd_abort     host commands (abort wins; load only from IDLE/DONE)
//   run_cycles              execution length, sampled on an accepted cmd_load (0 = free-run)
//   cfg                     entry stream (slave modport)
//   config_*                registered copy of the last accepted entry
//   write_config_data       one-cycle strobe per in-range accepted entry
//   start_exec              high for every RUN cycle
//   mapping_context_max_id  largest in-range cfg_index accepted in this load
//   busy, done, cfg_error   status (done and cfg_error are sticky until the next load)
// Optional: define CGRA_CTRL_CYCLE_COUNT_EN to add load_cycles/exec_cycles residency counters.
module cgra_exec_controller
  import cgra_exec_controller_pkg::*;
#(
  parameter int RUN_CNT_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               cmd_load,
  input  logic                               cmd_abort,
  input  logic [RUN_CNT_WIDTH-1:0]           run_cycles,
  cgra_exec_controller_if.slave              cfg,
  output logic [PE_ROW_BIT_LENGTH-1:0]       config_row,
  output logic [PE_COLUMN_BIT_LENGTH-1:0]    config_col,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_pe1,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_pe2,
  output logic [NEIGHBOR_PE_NUM-1:0]         config_output_pe,
  output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
  output logic [DATA_WIDTH-1:0]              config_const,
  output logic                               write_config_data,
  output logic                               start_exec,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
  output logic                               busy,
  output logic                               done,
  output logic                               cfg_error
`ifdef CGRA_CTRL_CYCLE_COUNT_EN
  ,
  output logic [31:0]                        load_cycles,
  output logic [31:0]                        exec_cycles
`endif
);

  ctrl_state_t state_q, state_d;
  cfg_entry_t  entry_s;
  cfg_entry_t  cfg_q, cfg_d;
  logic        accept_s, in_range_s, load_go_s, run_en_s, run_term_s;
  logic        strobe_q, strobe_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_id_q, max_id_d;

  assign entry_s = '{row: cfg.cfg_row, col: cfg.cfg_col, index: cfg.cfg_index,
                     in1: cfg.cfg_in1, in2: cfg.cfg_in2, out: cfg.cfg_out,
                     op: cfg.cfg_op, const_data: cfg.cfg_const};

  assign cfg.cfg_ready = ready_q;
  assign accept_s      = cfg.cfg_valid && ready_q;
  assign in_range_s    = entry_in_range(entry_s);
  // A load command only counts when idle/done and not overridden by abort.
  assign load_go_s     = cmd_load && !cmd_abort && ((state_q == IDLE) || (state_q == DONE));
  assign run_en_s      = (state_q == RUN);

  cgra_ctrl_run_counter #(.WIDTH(RUN_CNT_WIDTH)) u_run_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load_go_s),
    .enable   (run_en_s),
    .limit    (run_cycles),
    .terminal (run_term_s)
  );

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    if (cmd_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = load_go_s ? LOAD : IDLE;
        LOAD:    state_d = (accept_s && cfg.cfg_last) ? ARM : LOAD;
        ARM:     state_d = RUN;
        RUN:     state_d = run_term_s ? DONE : RUN;
        DONE:    state_d = load_go_s ? LOAD : DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Entry capture, strobe, max-id and sticky status updates.
  always_comb begin
    cfg_d    = cfg_q;
    strobe_d = 1'b0;
    max_id_d = max_id_q;
    err_d    = err_q;
    done_d   = done_q;
    if (load_go_s) begin
      max_id_d = {CONTEXT_SIZE_BIT_LENGTH{1'b0}};
      err_d    = 1'b0;
      done_d   = 1'b0;
    end else if (accept_s) begin
      // Out-of-range entries are still captured and still end the load, but never strobe.
      cfg_d = entry_s;
      if (in_range_s) begin
        strobe_d = 1'b1;
        if (entry_s.index > max_id_q) begin
          max_id_d = entry_s.index;
        end else begin
          max_id_d = max_id_q;
        end
      end else begin
        err_d = 1'b1;
      end
    end else if ((state_q == RUN) && (state_d == DONE)) begin
      done_d = 1'b1;
    end else begin
      done_d = done_q;
    end
  end

  // Status outputs are registered from the next state so they track state_q exactly.
  always_comb begin
    start_d = (state_d == RUN);
    busy_d  = (state_d == LOAD) || (state_d == ARM) || (state_d == RUN);
    ready_d = (state_d == LOAD);
  end

  // Controller registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cfg_q    <= '0;
      strobe_q <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      max_id_q <= {CONTEXT_SIZE_BIT_LENGTH{1'b0}};
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      strobe_q <= strobe_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      max_id_q <= max_id_d;
    end
  end

  assign config_row             = cfg_q.row;
  assign config_col             = cfg_q.col;
  assign config_index           = cfg_q.index;
  assign config_input_pe1       = cfg_q.in1;
  assign config_input_pe2       = cfg_q.in2;
  assign config_output_pe       = cfg_q.out;
  assign config_op              = cfg_q.op;
  assign config_const           = cfg_q.const_data;
  assign write_config_data      = strobe_q;
  assign start_exec             = start_q;
  assign mapping_context_max_id = max_id_q;
  assign busy                   = busy_q;
  assign done                   = done_q;
  assign cfg_error              = err_q;

`ifdef CGRA_CTRL_CYCLE_COUNT_EN
  logic [31:0] load_cyc_q, load_cyc_d;
  logic [31:0] exec_cyc_q, exec_cyc_d;

  // Residency counters: clear on a new load, saturate at all-ones, hold elsewhere.
  always_comb begin
    load_cyc_d = load_cyc_q;
    exec_cyc_d = exec_cyc_q;
    if (load_go_s) begin
      load_cyc_d = 32'd0;
      exec_cyc_d = 32'd0;
    end else begin
      if ((state_q == LOAD) && (load_cyc_q != 32'hFFFF_FFFF)) begin
        load_cyc_d = load_cyc_q + 32'd1;
      end else begin
        load_cyc_d = load_cyc_q;
      end
      if ((state_q == RUN) && (exec_cyc_q != 32'hFFFF_FFFF)) begin
        exec_cyc_d = exec_cyc_q + 32'd1;
      end else begin
        exec_cyc_d = exec_cyc_q;
      end
    end
  end

  // Residency counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_cyc_q <= 32'd0;
      exec_cyc_q <= 32'd0;
    end else begin
      load_cyc_q <= load_cyc_d;
      exec_cyc_q <= exec_cyc_d;
    end
  end

  assign load_cycles = load_cyc_q;
  assign exec_cycles = exec_cyc_q;
`endif

endmodule

// File: tb/tb_cgra_exec_controller.sv
// Self-checking bench for cgra_exec_controller.
// Loads are described as lists of entries; the expected strobes, error flag, max id and
// execution length are derived from those lists, and a monitor records what the DUT did
// (accept/strobe cycles and data, start_exec cycles) for comparison.
`timescale 1ns/1ps
module tb_cgra_exec_controller;
  import cgra_exec_controller_pkg::*;

  typedef struct {
    cfg_entry_t e;
    logic       last;
    int         gap;
  } tb_ent_t;

  typedef struct {
    logic [1:0] row;
    logic [1:0] col;
    logic [2:0] idx;
    int         run;
    int         exp_stb;
    logic       exp_err;
    int         exp_max;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_load = 1'b0;
  logic        cmd_abort = 1'b0;
  logic [31:0] run_cycles = 32'd0;

  logic [PE_ROW_BIT_LENGTH-1:0]       config_row;
  logic [PE_COLUMN_BIT_LENGTH-1:0]    config_col;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_pe1;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_pe2;
  logic [NEIGHBOR_PE_NUM-1:0]         config_output_pe;
  logic [OPERATION_BIT_LENGTH-1:0]    config_op;
  logic [DATA_WIDTH-1:0]              config_const;
  logic write_config_data, start_exec, busy, done, cfg_error;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id;
`ifdef CGRA_CTRL_CYCLE_COUNT_EN
  logic [31:0] load_cycles, exec_cycles;
`endif

  cgra_exec_controller_if cfg_if ();

  cgra_exec_controller dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .cmd_load               (cmd_load),
    .cmd_abort              (cmd_abort),
    .run_cycles             (run_cycles),
    .cfg                    (cfg_if.slave),
    .config_row             (config_row),
    .config_col             (config_col),
    .config_index           (config_index),
    .config_input_pe1       (config_input_pe1),
    .config_input_pe2       (config_input_pe2),
    .config_output_pe       (config_output_pe),
    .config_op              (config_op),
    .config_const           (config_const),
    .write_config_data      (write_config_data),
    .start_exec             (start_exec),
    .mapping_context_max_id (mapping_context_max_id),
    .busy                   (busy),
    .done                   (done),
    .cfg_error              (cfg_error)
`ifdef CGRA_CTRL_CYCLE_COUNT_EN
    ,
    .load_cycles            (load_cycles),
    .exec_cycles            (exec_cycles)
`endif
  );

  always #5 clk = ~clk;

  cfg_entry_t out_cfg;
  assign out_cfg = '{row: config_row, col: config_col, index: config_index,
                     in1: config_input_pe1, in2: config_input_pe2, out: config_output_pe,
                     op: config_op, const_data: config_const};

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         acc_cyc[$];
  int         stb_cyc[$];
  cfg_entry_t stb_ent[$];
  int         high_cyc[$];
  int         unstable = 0;
  cfg_entry_t prev_cfg = '0;
  int         load_c0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (cfg_if.cfg_valid && cfg_if.cfg_ready) acc_cyc.push_back(cyc);
      if (write_config_data) begin
        stb_cyc.push_back(cyc);
        stb_ent.push_back(out_cfg);
      end
      if (start_exec) high_cyc.push_back(cyc);
      if ((out_cfg != prev_cfg) && !write_config_data) unstable++;
      prev_cfg = out_cfg;
    end
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    acc_cyc.delete();
    stb_cyc.delete();
    stb_ent.delete();
    high_cyc.delete();
  endtask

  function automatic logic tb_in_range(input cfg_entry_t e);
    return (int'(e.row) < PE_ROW_SIZE) && (int'(e.col) < PE_COLUMN_SIZE);
  endfunction

  function automatic tb_ent_t mk(input int row, input int col, input int idx,
                                 input logic last, input int gap);
    tb_ent_t t;
    t.e.row        = 2'(row);
    t.e.col        = 2'(col);
    t.e.index      = 3'(idx);
    t.e.in1        = 3'($urandom_range(0, 7));
    t.e.in2        = 3'($urandom_range(0, 7));
    t.e.out        = 4'($urandom_range(1, 15));
    t.e.op         = 4'($urandom_range(1, 15));
    t.e.const_data = 16'($urandom_range(1, 65535));
    t.last = last;
    t.gap  = gap;
    return t;
  endfunction

  // Issue cmd_load, then stream the entries (each preceded by its idle gap).
  task automatic do_stream(input tb_ent_t ents[$], input int run);
    logic got;
    clr_mon();
    run_cycles = 32'(run);
    cmd_load = 1'b1;
    load_c0 = cyc;
    tick();
    cmd_load = 1'b0;
    foreach (ents[i]) begin
      repeat (ents[i].gap) tick();
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_last  = ents[i].last;
      cfg_if.cfg_row   = ents[i].e.row;
      cfg_if.cfg_col   = ents[i].e.col;
      cfg_if.cfg_index = ents[i].e.index;
      cfg_if.cfg_in1   = ents[i].e.in1;
      cfg_if.cfg_in2   = ents[i].e.in2;
      cfg_if.cfg_out   = ents[i].e.out;
      cfg_if.cfg_op    = ents[i].e.op;
      cfg_if.cfg_const = ents[i].e.const_data;
      got = 1'b0;
      for (int g = 0; g < 20 && !got; g++) begin
        @(negedge clk);
        got = cfg_if.cfg_ready;
        tick();
      end
      if (!got) chk("accept_timeout", 64'd0, 64'd1);
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_last  = 1'b0;
    end
  endtask

  task automatic wait_start(input string tag);
    logic seen = 1'b0;
    for (int g = 0; g < 20 && !seen; g++) begin
      @(negedge clk);
      seen = start_exec;
    end
    chk({tag, "_start_seen"}, 64'(seen), 64'd1);
  endtask

  // Wait for done and compare everything the load should have produced.
  task automatic finish_check(input string tag, input tb_ent_t ents[$], input int run);
    cfg_entry_t exp_q[$];
    int         exp_idx[$];
    logic       exp_err = 1'b0;
    int         exp_max = 0;
    logic       seen = 1'b0;
    foreach (ents[i]) begin
      if (tb_in_range(ents[i].e)) begin
        exp_q.push_back(ents[i].e);
        exp_idx.push_back(i);
        if (int'(ents[i].e.index) > exp_max) exp_max = int'(ents[i].e.index);
      end else begin
        exp_err = 1'b1;
      end
    end
    for (int g = 0; g < run + 20 && !seen; g++) begin
      @(negedge clk);
      seen = done;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_accepts"}, 64'(acc_cyc.size()), 64'(ents.size()));
    chk({tag, "_strobes"}, 64'(stb_ent.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < stb_ent.size(); i++) begin
      chk({tag, "_strobe_data"}, 64'(stb_ent[i]), 64'(exp_q[i]));
      if (exp_idx[i] < acc_cyc.size())
        chk({tag, "_strobe_lat"}, 64'(stb_cyc[i]), 64'(acc_cyc[exp_idx[i]] + 1));
    end
    chk({tag, "_err"}, 64'(cfg_error), 64'(exp_err));
    chk({tag, "_max_id"}, 64'(mapping_context_max_id), 64'(exp_max));
    chk({tag, "_high_cycles"}, 64'(high_cyc.size()), 64'(run));
    if (high_cyc.size() > 0 && acc_cyc.size() > 0) begin
      chk({tag, "_arm_gap"}, 64'(high_cyc[0]), 64'(acc_cyc[$] + 2));
      chk({tag, "_contig"}, 64'(high_cyc[$] - high_cyc[0] + 1), 64'(run));
    end
    chk({tag, "_start_low"}, 64'(start_exec), 64'd0);
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tb_ent_t ents[$];
    vec_t    vtab[5];
    int      u0, run, n, abort_cyc;

    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_last  = 1'b0;
    cfg_if.cfg_row   = '0;
    cfg_if.cfg_col   = '0;
    cfg_if.cfg_index = '0;
    cfg_if.cfg_in1   = '0;
    cfg_if.cfg_in2   = '0;
    cfg_if.cfg_out   = '0;
    cfg_if.cfg_op    = '0;
    cfg_if.cfg_const = '0;

    // Single-entry loads: row/col on and past the array edge.
    vtab[0] = '{row: 2'd0, col: 2'd0, idx: 3'd3, run: 2, exp_stb: 1, exp_err: 1'b0, exp_max: 3};
    vtab[1] = '{row: 2'd2, col: 2'd2, idx: 3'd7, run: 1, exp_stb: 1, exp_err: 1'b0, exp_max: 7};
    vtab[2] = '{row: 2'd3, col: 2'd0, idx: 3'd5, run: 3, exp_stb: 0, exp_err: 1'b1, exp_max: 0};
    vtab[3] = '{row: 2'd1, col: 2'd3, idx: 3'd4, run: 2, exp_stb: 0, exp_err: 1'b1, exp_max: 0};
    vtab[4] = '{row: 2'd3, col: 2'd3, idx: 3'd6, run: 1, exp_stb: 0, exp_err: 1'b1, exp_max: 0};

    // Reset state.
    #12;
    chk("rst_start_exec", 64'(start_exec), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(cfg_error), 64'd0);
    chk("rst_strobe", 64'(write_config_data), 64'd0);
    chk("rst_cfg", 64'(out_cfg), 64'd0);
    chk("rst_max_id", 64'(mapping_context_max_id), 64'd0);
    chk("rst_ready", 64'(cfg_if.cfg_ready), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Three back-to-back entries, idx 0,2,1, run 5.
    ents.delete();
    ents.push_back(mk(0, 1, 0, 1'b0, 0));
    ents.push_back(mk(1, 2, 2, 1'b0, 0));
    ents.push_back(mk(2, 0, 1, 1'b1, 0));
    do_stream(ents, 5);
    finish_check("b2b", ents, 5);
    if (stb_cyc.size() == 3) begin
      chk("b2b_consec01", 64'(stb_cyc[1]), 64'(stb_cyc[0] + 1));
      chk("b2b_consec12", 64'(stb_cyc[2]), 64'(stb_cyc[1] + 1));
    end else begin
      chk("b2b_nstrobe", 64'(stb_cyc.size()), 64'd3);
    end
    chk("b2b_max_id2", 64'(mapping_context_max_id), 64'd2);

    // Table vectors.
    for (int v = 0; v < 5; v++) begin
      ents.delete();
      ents.push_back(mk(int'(vtab[v].row), int'(vtab[v].col), int'(vtab[v].idx), 1'b1, 0));
      do_stream(ents, vtab[v].run);
      finish_check($sformatf("vec%0d", v), ents, vtab[v].run);
      chk($sformatf("vec%0d_tab_stb", v), 64'(stb_ent.size()), 64'(vtab[v].exp_stb));
      chk($sformatf("vec%0d_tab_err", v), 64'(cfg_error), 64'(vtab[v].exp_err));
      chk($sformatf("vec%0d_tab_max", v), 64'(mapping_context_max_id), 64'(vtab[v].exp_max));
    end

    // Valid with gaps: config bus only changes on strobe cycles.
    ents.delete();
    ents.push_back(mk(0, 0, 1, 1'b0, 1));
    ents.push_back(mk(1, 1, 4, 1'b0, 2));
    ents.push_back(mk(2, 1, 2, 1'b1, 1));
    u0 = unstable;
    do_stream(ents, 3);
    finish_check("gaps", ents, 3);
    chk("gaps_cfg_stable", 64'(unstable - u0), 64'd0);

    // Randomised loads against the list-based model.
    for (int r = 0; r < 15; r++) begin
      ents.delete();
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++)
        ents.push_back(mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7),
                          (k == n - 1), $urandom_range(0, 2)));
      run = $urandom_range(1, 8);
      do_stream(ents, run);
      finish_check($sformatf("rnd%0d", r), ents, run);
    end

    // cmd_load during RUN is ignored.
    ents.delete();
    ents.push_back(mk(1, 1, 3, 1'b1, 0));
    do_stream(ents, 6);
    wait_start("ignld");
    tick();
    run_cycles = 32'd40;
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    finish_check("ignld", ents, 6);

    // Abort in LOAD together with an accept: the scheduled strobe still fires.
    clr_mon();
    run_cycles = 32'd5;
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    ents.delete();
    ents.push_back(mk(2, 2, 5, 1'b0, 0));
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_last  = 1'b0;
    cfg_if.cfg_row   = ents[0].e.row;
    cfg_if.cfg_col   = ents[0].e.col;
    cfg_if.cfg_index = ents[0].e.index;
    cfg_if.cfg_in1   = ents[0].e.in1;
    cfg_if.cfg_in2   = ents[0].e.in2;
    cfg_if.cfg_out   = ents[0].e.out;
    cfg_if.cfg_op    = ents[0].e.op;
    cfg_if.cfg_const = ents[0].e.const_data;
    cmd_abort = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0;
    cmd_abort = 1'b0;
    @(negedge clk);
    chk("ldabort_strobe", 64'(write_config_data), 64'd1);
    chk("ldabort_data", 64'(out_cfg), 64'(ents[0].e));
    chk("ldabort_ready", 64'(cfg_if.cfg_ready), 64'd0);
    chk("ldabort_busy", 64'(busy), 64'd0);
    tick();
    @(negedge clk);
    chk("ldabort_strobe_once", 64'(write_config_data), 64'd0);

    // Abort + load together during RUN.
    ents.delete();
    ents.push_back(mk(0, 2, 1, 1'b1, 0));
    do_stream(ents, 50);
    wait_start("abrun");
    tick();
    tick();
    cmd_abort = 1'b1;
    cmd_load = 1'b1;
    tick();
    cmd_abort = 1'b0;
    cmd_load = 1'b0;
    @(negedge clk);
    chk("abrun_start", 64'(start_exec), 64'd0);
    chk("abrun_busy", 64'(busy), 64'd0);
    chk("abrun_done", 64'(done), 64'd0);
    chk("abrun_ready", 64'(cfg_if.cfg_ready), 64'd0);
    repeat (3) tick();
    @(negedge clk);
    chk("abrun_start_later", 64'(start_exec), 64'd0);
    chk("abrun_done_later", 64'(done), 64'd0);

    // run_cycles = 0: free-run until abort.
    ents.delete();
    ents.push_back(mk(1, 0, 6, 1'b1, 0));
    do_stream(ents, 0);
    wait_start("free");
    repeat (120) tick();
    @(negedge clk);
    chk("free_start", 64'(start_exec), 64'd1);
    chk("free_done", 64'(done), 64'd0);
    chk("free_busy", 64'(busy), 64'd1);
    tick();
    cmd_abort = 1'b1;
    abort_cyc = cyc;
    tick();
    cmd_abort = 1'b0;
    @(negedge clk);
    chk("free_stop", 64'(start_exec), 64'd0);
    chk("free_over100", 64'(high_cyc.size() > 100), 64'd1);
    if (high_cyc.size() > 0) begin
      chk("free_high_cnt", 64'(high_cyc.size()), 64'(abort_cyc - high_cyc[0] + 1));
      chk("free_last_high", 64'(high_cyc[$]), 64'(abort_cyc));
    end
`ifdef CGRA_CTRL_CYCLE_COUNT_EN
    chk("free_exec_cycles", 64'(exec_cycles), 64'(high_cyc.size()));
    if (acc_cyc.size() > 0)
      chk("free_load_cycles", 64'(load_cycles), 64'(acc_cyc[$] - load_c0));
`endif

    // Asynchronous reset in the middle of RUN.
    ents.delete();
    ents.push_back(mk(2, 1, 7, 1'b1, 0));
    do_stream(ents, 50);
    wait_start("rstrun");
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstrun_start", 64'(start_exec), 64'd0);
    chk("rstrun_busy", 64'(busy), 64'd0);
    chk("rstrun_strobe", 64'(write_config_data), 64'd0);
    chk("rstrun_cfg", 64'(out_cfg), 64'd0);
    chk("rstrun_max_id", 64'(mapping_context_max_id), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    chk("rstrun_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
